// File: rtl/mem_arbiter_if.sv
`default_nettype none
// mem_arbiter_if: fetch/mem-stage request ports and the external memory bus of mem_arbiter.
// Rev 1.0
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic                inst_req;
    logic [AW-1:0]       inst_addr;
    logic [DW-1:0]       inst_rdata;
    logic                inst_ok;

    logic                data_req;
    logic [DW/8-1:0]     data_wen;
    logic [AW-1:0]       data_addr;
    logic [DW-1:0]       data_wdata;
    logic [DW-1:0]       data_rdata;
    logic                data_ok;

    logic                advance;
    logic                stall;

    logic                mem_req;
    logic [DW/8-1:0]     mem_wen;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;
    logic                mem_ack;

    // Arbiter side
    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_ok,
        input  data_req, data_wen, data_addr, data_wdata,
        output data_rdata, data_ok,
        input  advance,
        output stall,
        output mem_req, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    // Pipeline and memory side
    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_ok,
        output data_req, data_wen, data_addr, data_wdata,
        input  data_rdata, data_ok,
        output advance,
        input  stall,
        input  mem_req, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one memory bus between fetch and mem stage, data first, results held until advance.
// Rev 1.0
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int WW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBUS = 2'd1,
        IBUS = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [WW-1:0]   mem_wen_q, mem_wen_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DW-1:0]   data_rdata_q, data_rdata_d;
    logic            inst_ok_q, inst_ok_d;
    logic            data_ok_q, data_ok_d;

    logic            w_inst_pend;
    logic            w_data_pend;

    assign w_inst_pend = bus.inst_req & ~inst_ok_q;
    assign w_data_pend = bus.data_req & ~data_ok_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_wen_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ok_d    = inst_ok_q;
        data_ok_d    = data_ok_q;

        // Advance clears both flags; a completion on the same edge overrides below.
        if (bus.advance) begin
            inst_ok_d = 1'b0;
            data_ok_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (w_data_pend) begin
                    state_d     = DBUS;
                    mem_req_d   = 1'b1;
                    mem_wen_d   = bus.data_wen;
                    mem_addr_d  = bus.data_addr;
                    mem_wdata_d = bus.data_wdata;
                end else if (w_inst_pend) begin
                    state_d     = IBUS;
                    mem_req_d   = 1'b1;
                    mem_wen_d   = '0;
                    mem_addr_d  = bus.inst_addr;
                    mem_wdata_d = '0;
                end
            end
            DBUS: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    data_ok_d = 1'b1;
                    // Stores leave the held load word untouched.
                    if (mem_wen_q == '0) begin
                        data_rdata_d = bus.mem_rdata;
                    end
                end
            end
            IBUS: begin
                if (bus.mem_ack) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    inst_ok_d    = 1'b1;
                    inst_rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign bus.stall      = w_inst_pend | w_data_pend;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.inst_ok    = inst_ok_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.data_ok    = data_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: vector table, corner-case sequences and a randomized run against a transaction-level model.
// Rev 1.0
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wen   = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.advance    = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwen;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        adv;
        logic        ack;
        logic [31:0] mrdata;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic [3:0]  e_mwen;
        logic        e_iok;
        logic        e_dok;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
        logic        e_stall;
    } vec_t;

    vec_t tbl [12];

    // Model state for the randomized phase
    bit          m_busy, m_isd, m_iok, m_dok, n_iok, n_dok, adv_prev, e_stall;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;
    logic [3:0]  m_wen;
    int          m_wait;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lone fetch, then both requesters at once, then spurious ack in idle.
        tbl[0]  = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        tbl[1]  = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h24080001,
                    1'b1, 32'hBFC00000, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        tbl[2]  = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h24080001, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h24080001, 32'h0, 1'b0};
        tbl[4]  = '{1'b1, 32'h00000100, 1'b1, 4'h0, 32'h80000010, 32'h0, 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h24080001, 32'h0, 1'b1};
        tbl[5]  = '{1'b1, 32'h00000100, 1'b1, 4'h0, 32'h80000010, 32'h0, 1'b0, 1'b1, 32'h11111111,
                    1'b1, 32'h80000010, 4'h0, 1'b0, 1'b0, 32'h24080001, 32'h0, 1'b1};
        tbl[6]  = '{1'b1, 32'h00000100, 1'b1, 4'h0, 32'h80000010, 32'h0, 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h24080001, 32'h11111111, 1'b1};
        tbl[7]  = '{1'b1, 32'h00000100, 1'b1, 4'h0, 32'h80000010, 32'h0, 1'b0, 1'b1, 32'h22222222,
                    1'b1, 32'h00000100, 4'h0, 1'b0, 1'b1, 32'h24080001, 32'h11111111, 1'b1};
        tbl[8]  = '{1'b1, 32'h00000100, 1'b1, 4'h0, 32'h80000010, 32'h0, 1'b1, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h22222222, 32'h11111111, 1'b0};
        tbl[9]  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h22222222, 32'h11111111, 1'b0};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF,
                    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h22222222, 32'h11111111, 1'b0};
        tbl[11] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h22222222, 32'h11111111, 1'b0};

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1 ("rst_mem_req", bus.mem_req, 1'b0);
        chk1 ("rst_inst_ok", bus.inst_ok, 1'b0);
        chk1 ("rst_data_ok", bus.data_ok, 1'b0);
        chk32("rst_inst_rdata", bus.inst_rdata, 32'h0);
        chk32("rst_data_rdata", bus.data_rdata, 32'h0);
        chk32("rst_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.inst_req   = tbl[i].ireq;
            bus.inst_addr  = tbl[i].iaddr;
            bus.data_req   = tbl[i].dreq;
            bus.data_wen   = tbl[i].dwen;
            bus.data_addr  = tbl[i].daddr;
            bus.data_wdata = tbl[i].dwdata;
            bus.advance    = tbl[i].adv;
            bus.mem_ack    = tbl[i].ack;
            bus.mem_rdata  = tbl[i].mrdata;
            #1;
            chk1 ($sformatf("vec%0d_mem_req", i), bus.mem_req, tbl[i].e_mreq);
            if (tbl[i].e_mreq) begin
                chk32($sformatf("vec%0d_mem_addr", i), bus.mem_addr, tbl[i].e_maddr);
                chk32($sformatf("vec%0d_mem_wen", i), 32'(bus.mem_wen), 32'(tbl[i].e_mwen));
            end
            chk1 ($sformatf("vec%0d_inst_ok", i), bus.inst_ok, tbl[i].e_iok);
            chk1 ($sformatf("vec%0d_data_ok", i), bus.data_ok, tbl[i].e_dok);
            chk32($sformatf("vec%0d_inst_rdata", i), bus.inst_rdata, tbl[i].e_ird);
            chk32($sformatf("vec%0d_data_rdata", i), bus.data_rdata, tbl[i].e_drd);
            chk1 ($sformatf("vec%0d_stall", i), bus.stall, tbl[i].e_stall);
            tick();
        end

        // Byte store with three bus wait cycles.
        idle_inputs();
        bus.data_req   = 1'b1;
        bus.data_wen   = 4'b0010;
        bus.data_addr  = 32'h0000000C;
        bus.data_wdata = 32'h00AB00AB;
        #1;
        chk1("st_stall0", bus.stall, 1'b1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            bus.mem_ack   = (k == 4);
            bus.mem_rdata = 32'hBAD0BAD0;
            #1;
            chk1 ($sformatf("st_c%0d_mem_req", k), bus.mem_req, 1'b1);
            chk32($sformatf("st_c%0d_mem_wen", k), 32'(bus.mem_wen), 32'h2);
            chk32($sformatf("st_c%0d_mem_addr", k), bus.mem_addr, 32'h0000000C);
            chk32($sformatf("st_c%0d_mem_wdata", k), bus.mem_wdata, 32'h00AB00AB);
            chk1 ($sformatf("st_c%0d_data_ok", k), bus.data_ok, 1'b0);
            tick();
        end
        bus.mem_ack = 1'b0;
        bus.advance = 1'b1;
        #1;
        chk1 ("st_c5_data_ok", bus.data_ok, 1'b1);
        chk32("st_c5_data_rdata", bus.data_rdata, 32'h11111111);
        chk1 ("st_c5_stall", bus.stall, 1'b0);
        chk1 ("st_c5_mem_req", bus.mem_req, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk1("st_c6_data_ok", bus.data_ok, 1'b0);
        tick();

        // Data done early, fetch waits five bus cycles, pipeline holds.
        for (int c = 0; c <= 9; c++) begin
            bus.inst_req  = (c <= 8);
            bus.inst_addr = 32'h00000200;
            bus.data_req  = (c <= 8);
            bus.data_wen  = 4'h0;
            bus.data_addr = 32'h00000300;
            bus.mem_ack   = (c == 1) || (c == 7);
            bus.mem_rdata = (c == 1) ? 32'hAAAA0001 : 32'hAAAA0002;
            bus.advance   = (c == 8);
            #1;
            chk1($sformatf("hold_c%0d_mem_req", c), bus.mem_req, (c == 1) || (c >= 3 && c <= 7));
            if (c == 1) chk32("hold_c1_mem_addr", bus.mem_addr, 32'h00000300);
            if (c >= 3 && c <= 7) chk32($sformatf("hold_c%0d_mem_addr", c), bus.mem_addr, 32'h00000200);
            chk1($sformatf("hold_c%0d_data_ok", c), bus.data_ok, (c >= 2 && c <= 8));
            chk1($sformatf("hold_c%0d_inst_ok", c), bus.inst_ok, (c == 8));
            chk1($sformatf("hold_c%0d_stall", c), bus.stall, (c <= 7));
            tick();
        end
        chk32("hold_data_rdata", bus.data_rdata, 32'hAAAA0001);
        chk32("hold_inst_rdata", bus.inst_rdata, 32'hAAAA0002);

        // Asynchronous reset in the middle of a fetch.
        idle_inputs();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h00000400;
        tick();
        chk1("arst_pre_mem_req", bus.mem_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1 ("arst_mem_req", bus.mem_req, 1'b0);
        chk1 ("arst_inst_ok", bus.inst_ok, 1'b0);
        chk32("arst_inst_rdata", bus.inst_rdata, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk1("arst_idle_mem_req", bus.mem_req, 1'b0);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00000055;
        #1;
        chk1 ("arst_reissue_mem_req", bus.mem_req, 1'b1);
        chk32("arst_reissue_addr", bus.mem_addr, 32'h00000400);
        tick();
        bus.mem_ack = 1'b0;
        bus.advance = 1'b1;
        #1;
        chk1 ("arst_inst_ok_after", bus.inst_ok, 1'b1);
        chk32("arst_inst_rdata_after", bus.inst_rdata, 32'h00000055);
        tick();

        // Randomized run against the transaction-level model.
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_busy = 1'b0; m_isd = 1'b0; m_iok = 1'b0; m_dok = 1'b0;
        m_ird = '0; m_drd = '0; m_addr = '0; m_wdata = '0; m_wen = '0; m_wait = 0;
        adv_prev = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (adv_prev) begin
                bus.inst_req   = ($urandom_range(0, 3) != 0);
                bus.inst_addr  = $urandom;
                bus.data_req   = ($urandom_range(0, 1) == 1);
                bus.data_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                bus.data_addr  = $urandom;
                bus.data_wdata = $urandom;
            end
            e_stall       = (bus.inst_req && !m_iok) || (bus.data_req && !m_dok);
            bus.advance   = !e_stall && ($urandom_range(0, 1) == 1);
            bus.mem_ack   = m_busy ? (m_wait == 0) : ($urandom_range(0, 7) == 0);
            bus.mem_rdata = $urandom;
            #1;
            chk1("rnd_stall", bus.stall, e_stall);
            chk1("rnd_mem_req", bus.mem_req, m_busy);
            if (m_busy) begin
                chk32("rnd_mem_addr", bus.mem_addr, m_addr);
                chk32("rnd_mem_wen", 32'(bus.mem_wen), 32'(m_wen));
                chk32("rnd_mem_wdata", bus.mem_wdata, m_wdata);
            end
            chk1 ("rnd_inst_ok", bus.inst_ok, m_iok);
            chk1 ("rnd_data_ok", bus.data_ok, m_dok);
            chk32("rnd_inst_rdata", bus.inst_rdata, m_ird);
            chk32("rnd_data_rdata", bus.data_rdata, m_drd);

            adv_prev = bus.advance;
            n_iok = bus.advance ? 1'b0 : m_iok;
            n_dok = bus.advance ? 1'b0 : m_dok;
            if (m_busy) begin
                if (bus.mem_ack) begin
                    m_busy = 1'b0;
                    if (m_isd) begin
                        n_dok = 1'b1;
                        if (m_wen == 4'h0) m_drd = bus.mem_rdata;
                    end else begin
                        n_iok = 1'b1;
                        m_ird = bus.mem_rdata;
                    end
                end else begin
                    m_wait--;
                end
            end else if (bus.data_req && !m_dok) begin
                m_busy  = 1'b1;
                m_isd   = 1'b1;
                m_addr  = bus.data_addr;
                m_wen   = bus.data_wen;
                m_wdata = bus.data_wdata;
                m_wait  = $urandom_range(0, 3);
            end else if (bus.inst_req && !m_iok) begin
                m_busy  = 1'b1;
                m_isd   = 1'b0;
                m_addr  = bus.inst_addr;
                m_wen   = 4'h0;
                m_wdata = 32'h0;
                m_wait  = $urandom_range(0, 3);
            end
            m_iok = n_iok;
            m_dok = n_dok;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
